data_memory_stage: RTL and testbench

//   MEM-stage data memory unit. Sits between the EX/MEM and MEM/WB pipeline buffers of the
//   5-stage RISC-V core. Executes LB/LH/LW/LBU/LHU/SB/SH/SW against an internal word-array
//   RAM with a configurable multi-cycle access latency. Raises stall_o to freeze the upstream

---
 rtl/data_memory_stage.sv | 174 +++++++++++++++++
 tb/tb_data_memory_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_stage.sv
// ============================================================================
// data_memory_stage
// ----------------------------------------------------------------------------
// MEM-stage data memory for a 5-stage RISC-V pipeline. Executes LB/LH/LW/
// LBU/LHU/SB/SH/SW against an internal word-array RAM. Each accepted access
// stalls the upstream pipeline for exactly LATENCY cycles. Misaligned or
// illegal accesses are dropped and flagged with a one-cycle error pulse.
//
// Ports
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous reset, active-low
//   mem_read_i   in   1   load request
//   mem_write_i  in   1   store request (wins over mem_read_i)
//   funct3_i     in   3   RISC-V funct3 width/sign selector
//   addr_i       in   32  byte address
//   wdata_i      in   32  store data
//   rdata_o      out  32  extended load data, registered
//   valid_o      out  1   pulse: rdata_o updated by a completed load
//   stall_o      out  1   freeze EX/MEM and earlier stages this cycle
//   err_o        out  1   pulse: access dropped (misaligned / illegal funct3)
// ============================================================================
module data_memory_stage #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] rdata_o,
   output logic        valid_o,
   output logic        stall_o,
   output logic        err_o
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t           state, state_nxt;
   logic [3:0]       cnt, cnt_nxt;
   logic [31:0]      ram [DEPTH_WORDS];

   logic             req;
   logic             is_store;
   logic             illegal;
   logic             misaligned;
   logic             fault;
   logic             accept;
   logic             complete;
   logic [IDX_W-1:0] idx;
   logic [1:0]       off;
   logic [31:0]      word;

   // Address bits above the index field are deliberately ignored so that
   // accesses wrap modulo the RAM size.
   logic             unused_addr_bits;
   assign unused_addr_bits = ^addr_i[31:IDX_W+2];

   // Select the addressed byte/half and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] w,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  o);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{o, 3'b000} +: 8];
      h = o[1] ? w[31:16] : w[15:0];
      case (f3)
         3'd0:    load_extend = {{24{b[7]}}, b};
         3'd1:    load_extend = {{16{h[15]}}, h};
         3'd4:    load_extend = {24'd0, b};
         3'd5:    load_extend = {16'd0, h};
         default: load_extend = w;
      endcase
   endfunction

   // Merge store data into the old word; lanes not written are preserved.
   function automatic logic [31:0] store_merge(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  o);
      logic [31:0] r;
      r = old;
      case (f3)
         3'd0: r[{o, 3'b000} +: 8] = wd[7:0];
         3'd1: begin
            if (o[1]) r[31:16] = wd[15:0];
            else      r[15:0]  = wd[15:0];
         end
         default: r = wd;
      endcase
      return r;
   endfunction

   assign idx  = addr_i[IDX_W+1:2];
   assign off  = addr_i[1:0];
   assign word = ram[idx];

   // Request decode and legality check.
   always_comb begin
      req        = mem_read_i | mem_write_i;
      is_store   = mem_write_i;
      if (is_store)
         illegal = (funct3_i > 3'd2);
      else
         illegal = (funct3_i == 3'd3) || (funct3_i[2:1] == 2'b11);
      misaligned = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                   ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
      fault      = req && (illegal || misaligned);
      // rst_i gates acceptance so stall_o drops the moment reset asserts.
      accept     = rst_i && (state == IDLE) && req && !fault;
      complete   = (state == BUSY) && (cnt == 4'd0);
      stall_o    = accept || ((state == BUSY) && (cnt != 4'd0));
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt == 4'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 4'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Output registers: load data, completion and error pulses.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         rdata_o <= 32'd0;
         valid_o <= 1'b0;
         err_o   <= 1'b0;
      end else begin
         err_o   <= (state == IDLE) && fault;
         valid_o <= complete && !is_store;
         if (complete && !is_store)
            rdata_o <= load_extend(word, funct3_i, off);
      end
   end

   // RAM: the store commits only on the completing edge, so a reset during
   // the stall window discards it.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH_WORDS; i++)
            ram[i] <= 32'd0;
      end else if (complete && is_store) begin
         ram[idx] <= store_merge(word, wdata_i, funct3_i, off);
      end
   end

endmodule

// File: tb/tb_data_memory_stage.sv
module tb_data_memory_stage;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [2:0]  funct3_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        valid_o;
   logic        stall_o;
   logic        err_o;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   data_memory_stage #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .mem_read_i  (mem_read_i),
      .mem_write_i (mem_write_i),
      .funct3_i    (funct3_i),
      .addr_i      (addr_i),
      .wdata_i     (wdata_i),
      .rdata_o     (rdata_o),
      .valid_o     (valid_o),
      .stall_o     (stall_o),
      .err_o       (err_o)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      mem_read_i  = rd;
      mem_write_i = wr;
      funct3_i    = f3;
      addr_i      = addr;
      wdata_i     = wd;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   // Legal access: expects 2 stalled cycles, then completion. Called #1 after a posedge.
   task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rdata);
      int n;
      n = 0;
      drive(rd, wr, f3, addr, wd);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (!stall_o) break;
         n++;
      end
      check({tag, " stall_cycles"}, 32'(n), 32'd2);
      @(posedge clk); #1;
      idle_inputs();
      check({tag, " valid"}, {31'd0, valid_o}, {31'd0, !wr});
      check({tag, " rdata"}, rdata_o, exp_rdata);
      @(posedge clk); #1;
      check({tag, " valid_drop"}, {31'd0, valid_o}, 32'd0);
   endtask

   // Faulting access: no stall, err pulse, rdata held.
   task automatic err_access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] exp_rdata);
      drive(rd, wr, f3, addr, 32'hFFFF_FFFF);
      @(negedge clk);
      check({tag, " no_stall"}, {31'd0, stall_o}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();
      check({tag, " err"}, {31'd0, err_o}, 32'd1);
      check({tag, " valid"}, {31'd0, valid_o}, 32'd0);
      check({tag, " rdata_held"}, rdata_o, exp_rdata);
      @(posedge clk); #1;
      check({tag, " err_drop"}, {31'd0, err_o}, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [5:0] pat;
      int         vcnt;

      rst_i = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      check("rst rdata", rdata_o, 32'd0);
      check("rst valid", {31'd0, valid_o}, 32'd0);
      check("rst stall", {31'd0, stall_o}, 32'd0);
      check("rst err",   {31'd0, err_o}, 32'd0);
      rst_i = 1'b1;
      @(posedge clk); #1;

      // 1: SW / LW
      access("t1 sw", 1'b0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'd0);
      access("t1 lw", 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'hDEADBEEF);

      // 2: byte store, signed/unsigned byte loads
      access("t2 sb",  1'b0, 1'b1, 3'd0, 32'h13, 32'h0000_0080, 32'hDEADBEEF);
      access("t2 lb",  1'b1, 1'b0, 3'd0, 32'h13, 32'd0, 32'hFFFFFF80);
      access("t2 lbu", 1'b1, 1'b0, 3'd4, 32'h13, 32'd0, 32'h00000080);
      access("t2 lw",  1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'h80ADBEEF);

      // 3: faults
      err_access("t3 lw_mis", 1'b1, 1'b0, 3'd2, 32'h12, 32'h80ADBEEF);
      err_access("t3 sh_mis", 1'b0, 1'b1, 3'd1, 32'h11, 32'h80ADBEEF);
      err_access("t3 f3_3",   1'b1, 1'b0, 3'd3, 32'h10, 32'h80ADBEEF);
      access("t3 lw_after", 1'b1, 1'b0, 3'd2, 32'h10, 32'd0, 32'h80ADBEEF);

      // 4: wrap-around and halfword lanes
      access("t4 sh",  1'b0, 1'b1, 3'd1, 32'h402, 32'h0000A5A5, 32'h80ADBEEF);
      access("t4 lw",  1'b1, 1'b0, 3'd2, 32'h0,   32'd0, 32'hA5A50000);
      access("t4 lhu", 1'b1, 1'b0, 3'd5, 32'h2,   32'd0, 32'h0000A5A5);
      access("t4 lh",  1'b1, 1'b0, 3'd1, 32'h2,   32'd0, 32'hFFFFA5A5);

      // 5: reset during first stall cycle aborts the store
      drive(1'b0, 1'b1, 3'd2, 32'h20, 32'h12345678);
      @(negedge clk);
      check("t5 stall_before", {31'd0, stall_o}, 32'd1);
      rst_i = 1'b0;
      #1;
      check("t5 stall_rst", {31'd0, stall_o}, 32'd0);
      check("t5 rdata_rst", rdata_o, 32'd0);
      check("t5 valid_rst", {31'd0, valid_o}, 32'd0);
      idle_inputs();
      @(negedge clk);
      rst_i = 1'b1;
      @(posedge clk); #1;
      access("t5 lw", 1'b1, 1'b0, 3'd2, 32'h20, 32'd0, 32'd0);

      // 6: back-to-back loads
      access("t6 sw0", 1'b0, 1'b1, 3'd2, 32'h10, 32'h11111111, 32'd0);
      access("t6 sw1", 1'b0, 1'b1, 3'd2, 32'h14, 32'h22222222, 32'd0);
      pat  = '0;
      vcnt = 0;
      drive(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pat  = {pat[4:0], stall_o};
         vcnt += int'(valid_o);
      end
      @(posedge clk); #1;
      drive(1'b1, 1'b0, 3'd2, 32'h14, 32'd0);
      check("t6 rdata_first", rdata_o, 32'h11111111);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         pat  = {pat[4:0], stall_o};
         vcnt += int'(valid_o);
      end
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
      vcnt += int'(valid_o);
      check("t6 stall_pattern", {26'd0, pat}, 32'b110110);
      check("t6 valid_pulses", 32'(vcnt), 32'd2);
      check("t6 rdata_second", rdata_o, 32'h22222222);

      // Idle: no request
      @(posedge clk); #1;
      @(negedge clk);
      check("idle stall", {31'd0, stall_o}, 32'd0);
      check("idle valid", {31'd0, valid_o}, 32'd0);
      check("idle err",   {31'd0, err_o}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
